// File: rtl/bp_nbf_cmd_issuer.sv
// bp_nbf_cmd_issuer: turns NBF loader beats into uncached write commands,
// tracks outstanding commands and handles fence / finish draining.
// Ports: clk_i, reset_n_i (async, active-low); nbf_i/nbf_v_i/nbf_ready_o
//   loader input; io_data_cmd_* write command out (yumi handshake);
//   io_resp_v_i/io_resp_ready_o response return; done_o, err_cnt_o status.
// Optional: define BP_NBF_CMD_ISSUER_ERR_CNT_EN to count unknown opcodes.
module bp_nbf_cmd_issuer #(
    parameter int paddr_width_p     = 40,
    parameter int data_width_p      = 512,
    parameter int max_outstanding_p = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic [8+paddr_width_p+63:0] nbf_i,
    input  logic                       nbf_v_i,
    output logic                       nbf_ready_o,
    output logic [paddr_width_p-1:0]   io_data_cmd_addr_o,
    output logic [data_width_p-1:0]    io_data_cmd_data_o,
    output logic [1:0]                 io_data_cmd_nc_size_o,
    output logic                       io_data_cmd_v_o,
    input  logic                       io_data_cmd_yumi_i,
    input  logic                       io_resp_v_i,
    output logic                       io_resp_ready_o,
    output logic                       done_o,
    output logic [7:0]                 err_cnt_o
);

    localparam int nbf_w_lp = 8 + paddr_width_p + 64;
    localparam int cnt_w_lp = $clog2(max_outstanding_p + 1);
    localparam logic [cnt_w_lp-1:0] max_lp = cnt_w_lp'(max_outstanding_p);
    localparam logic [cnt_w_lp-1:0] one_lp = cnt_w_lp'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FENCE = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    logic                     finish_q, finish_d;
    logic [cnt_w_lp-1:0]      cnt_q, cnt_d;
    logic [paddr_width_p-1:0] addr_q, addr_d;
    logic [63:0]              data_q, data_d;
    logic [1:0]               size_q, size_d;

    logic [7:0]               nbf_op;
    logic [paddr_width_p-1:0] nbf_addr;
    logic [63:0]              nbf_data;
    logic                     accept;
    logic                     cmd_v;
    logic                     yumi_ok;

    assign nbf_op   = nbf_i[nbf_w_lp-1 -: 8];
    assign nbf_addr = nbf_i[64 +: paddr_width_p];
    assign nbf_data = nbf_i[63:0];

    assign accept  = nbf_v_i && (state_q == IDLE);
    assign cmd_v   = (state_q == ISSUE) && (cnt_q < max_lp);
    assign yumi_ok = io_data_cmd_yumi_i && cmd_v;

    // A yumi and a response in the same cycle cancel out.
    always_comb begin
        cnt_d = cnt_q;
        if (yumi_ok && !io_resp_v_i) begin
            cnt_d = cnt_q + one_lp;
        end else if (!yumi_ok && io_resp_v_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - one_lp;
        end
    end

    always_comb begin
        state_d  = state_q;
        finish_d = finish_q;
        addr_d   = addr_q;
        data_d   = data_q;
        size_d   = size_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    unique case (nbf_op)
                        8'h02: begin
                            addr_d  = nbf_addr;
                            data_d  = {32'b0, nbf_data[31:0]};
                            size_d  = 2'd2;
                            state_d = ISSUE;
                        end
                        8'h03: begin
                            addr_d  = nbf_addr;
                            data_d  = nbf_data;
                            size_d  = 2'd3;
                            state_d = ISSUE;
                        end
                        8'hFE: begin
                            finish_d = 1'b0;
                            state_d  = FENCE;
                        end
                        8'hFF: begin
                            finish_d = 1'b1;
                            state_d  = FENCE;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
            ISSUE: begin
                if (yumi_ok) begin
                    state_d = IDLE;
                end
            end
            // Leave as soon as the final response lands (next-state count).
            FENCE: begin
                if (cnt_d == '0) begin
                    state_d = finish_q ? DONE : IDLE;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= IDLE;
            finish_q <= 1'b0;
            cnt_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            size_q   <= '0;
        end else begin
            state_q  <= state_d;
            finish_q <= finish_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            size_q   <= size_d;
        end
    end

`ifdef BP_NBF_CMD_ISSUER_ERR_CNT_EN
    logic [7:0] err_q, err_d;
    logic       unk;

    assign unk = (nbf_op != 8'h02) && (nbf_op != 8'h03) &&
                 (nbf_op != 8'hFE) && (nbf_op != 8'hFF);

    always_comb begin
        err_d = err_q;
        if (accept && unk && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_cnt_o = err_q;
`else
    assign err_cnt_o = '0;
`endif

    assign nbf_ready_o           = (state_q == IDLE);
    assign io_data_cmd_v_o       = cmd_v;
    assign io_data_cmd_addr_o    = addr_q;
    assign io_data_cmd_data_o    = {{(data_width_p-64){1'b0}}, data_q};
    assign io_data_cmd_nc_size_o = size_q;
    assign io_resp_ready_o       = 1'b1;
    assign done_o                = (state_q == DONE);

endmodule

// File: tb/tb_bp_nbf_cmd_issuer.sv
// tb_bp_nbf_cmd_issuer: table vectors plus corner sequences; issued
// commands are checked against a scoreboard queue filled at accept time.
module tb_bp_nbf_cmd_issuer;

    localparam int PA = 40;
    localparam int DW = 512;
    localparam int MO = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [PA+71:0]  nbf = '0;
    logic            nbf_v = 1'b0;
    logic            nbf_ready;
    logic [PA-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_data;
    logic [1:0]      cmd_size;
    logic            cmd_v;
    logic            yumi = 1'b0;
    logic            resp_v = 1'b0;
    logic            resp_ready;
    logic            done;
    logic [7:0]      err_cnt;

    always #5 clk = ~clk;

    bp_nbf_cmd_issuer #(
        .paddr_width_p    (PA),
        .data_width_p     (DW),
        .max_outstanding_p(MO)
    ) dut (
        .clk_i                (clk),
        .reset_n_i            (rst_n),
        .nbf_i                (nbf),
        .nbf_v_i              (nbf_v),
        .nbf_ready_o          (nbf_ready),
        .io_data_cmd_addr_o   (cmd_addr),
        .io_data_cmd_data_o   (cmd_data),
        .io_data_cmd_nc_size_o(cmd_size),
        .io_data_cmd_v_o      (cmd_v),
        .io_data_cmd_yumi_i   (yumi),
        .io_resp_v_i          (resp_v),
        .io_resp_ready_o      (resp_ready),
        .done_o               (done),
        .err_cnt_o            (err_cnt)
    );

    typedef struct {
        logic [PA-1:0] addr;
        logic [63:0]   data;
        logic [1:0]    size;
    } cmd_t;

    typedef struct {
        logic [7:0]    op;
        logic [PA-1:0] addr;
        logic [63:0]   data;
        logic          wr;
        logic [63:0]   exp_data;
        logic [1:0]    exp_size;
    } vec_t;

    cmd_t sb[$];
    cmd_t mon_e;
    vec_t vt[7];
    int   tests = 0;
    int   fails = 0;
    int   yumi_cnt = 0;
    int   base;
    int   exp_err = 0;
    logic yumi_en = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Auto-yumi monitor: consumes each valid command and checks it.
    always @(negedge clk) begin
        if (yumi_en && cmd_v) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_cmd: got addr %0h expected none",
                         cmd_addr);
            end else begin
                mon_e = sb.pop_front();
                chk("cmd_addr", 128'(cmd_addr), 128'(mon_e.addr));
                chk("cmd_data_lo", 128'(cmd_data[63:0]), 128'(mon_e.data));
                chk("cmd_data_hi", 128'(|cmd_data[DW-1:64]), 128'(0));
                chk("cmd_size", 128'(cmd_size), 128'(mon_e.size));
            end
            yumi = 1'b1;
            yumi_cnt++;
        end else begin
            yumi = 1'b0;
        end
    end

    task automatic send(input logic [7:0] op, input logic [PA-1:0] a,
                        input logic [63:0] d, input logic wr,
                        input logic [63:0] ed, input logic [1:0] es);
        int n = 0;
        cmd_t e;
        @(negedge clk);
        nbf   = {op, a, d};
        nbf_v = 1'b1;
        while (!nbf_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!nbf_ready) begin
            chk("send_timeout", 128'(nbf_ready), 128'(1));
            nbf_v = 1'b0;
            return;
        end
        if (wr) begin
            e.addr = a;
            e.data = ed;
            e.size = es;
            sb.push_back(e);
        end
        @(negedge clk);
        nbf_v = 1'b0;
    endtask

    task automatic w8(input logic [PA-1:0] a, input logic [63:0] d);
        send(8'h03, a, d, 1'b1, d, 2'd3);
    endtask

    task automatic ctl(input logic [7:0] op);
        send(op, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic wait_sb_empty();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("sb_drain", 128'(sb.size()), 128'(0));
    endtask

    task automatic resp_pulse();
        @(negedge clk);
        resp_v = 1'b1;
        @(negedge clk);
        resp_v = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{8'h03, 40'h0080000008, 64'h1122334455667788, 1'b1,
                  64'h1122334455667788, 2'd3};
        vt[1] = '{8'h02, 40'h0000001000, 64'hDEADBEEFCAFEF00D, 1'b1,
                  64'h00000000CAFEF00D, 2'd2};
        vt[2] = '{8'h55, 40'h0000002000, 64'h0123456789ABCDEF, 1'b0,
                  64'h0, 2'd0};
        vt[3] = '{8'h03, 40'hFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1,
                  64'hFFFFFFFFFFFFFFFF, 2'd3};
        vt[4] = '{8'h02, 40'h0000000000, 64'hFFFFFFFF00000001, 1'b1,
                  64'h0000000000000001, 2'd2};
        vt[5] = '{8'hAA, 40'h0000003000, 64'h5555555555555555, 1'b0,
                  64'h0, 2'd0};
        vt[6] = '{8'h03, 40'h123456789A, 64'h0, 1'b1, 64'h0, 2'd3};

        repeat (3) @(negedge clk);
        chk("rst_ready", 128'(nbf_ready), 128'(1));
        chk("rst_v", 128'(cmd_v), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_err", 128'(err_cnt), 128'(0));
        chk("rst_addr", 128'(cmd_addr), 128'(0));
        chk("rst_data", 128'(|cmd_data), 128'(0));
        chk("rst_size", 128'(cmd_size), 128'(0));
        chk("resp_ready", 128'(resp_ready), 128'(1));
        rst_n = 1'b1;
        yumi_en = 1'b1;

        for (int i = 0; i < 7; i++) begin
            send(vt[i].op, vt[i].addr, vt[i].data, vt[i].wr,
                 vt[i].exp_data, vt[i].exp_size);
            if (vt[i].wr) begin
                chk("lat_v", 128'(cmd_v), 128'(1));
                wait_sb_empty();
                resp_pulse();
            end else begin
                chk("unk_no_v", 128'(cmd_v), 128'(0));
`ifdef BP_NBF_CMD_ISSUER_ERR_CNT_EN
                exp_err++;
`endif
            end
        end
        chk("err_cnt_tbl", 128'(err_cnt), 128'(exp_err));

        // Outstanding cap: fifth write waits for one response.
        base = yumi_cnt;
        for (int i = 0; i < 5; i++) begin
            w8(40'h100 + 40'(i * 8), 64'hA5A5_0000_0000_0000 + 64'(i));
        end
        repeat (5) @(negedge clk);
        chk("cap_v_low", 128'(cmd_v), 128'(0));
        chk("cap_yumis", 128'(yumi_cnt - base), 128'(4));
        chk("cap_ready", 128'(nbf_ready), 128'(0));
        chk("cap_pending", 128'(sb.size()), 128'(1));
        resp_pulse();
        wait_sb_empty();
        chk("cap_yumis2", 128'(yumi_cnt - base), 128'(5));
        repeat (4) resp_pulse();

        // Fence waits for both responses.
        w8(40'h200, 64'h1);
        w8(40'h208, 64'h2);
        ctl(8'hFE);
        chk("fence_rdy0", 128'(nbf_ready), 128'(0));
        @(negedge clk);
        resp_v = 1'b1;
        chk("fence_rdy1", 128'(nbf_ready), 128'(0));
        @(negedge clk);
        resp_v = 1'b0;
        chk("fence_rdy2", 128'(nbf_ready), 128'(0));
        @(negedge clk);
        chk("fence_rdy3", 128'(nbf_ready), 128'(0));
        @(negedge clk);
        resp_v = 1'b1;
        chk("fence_rdy4", 128'(nbf_ready), 128'(0));
        @(negedge clk);
        resp_v = 1'b0;
        chk("fence_release", 128'(nbf_ready), 128'(1));

        // Unknown opcodes from a clean reset.
        do_reset();
        chk("err_rst", 128'(err_cnt), 128'(0));
        repeat (3) ctl(8'h55);
        repeat (2) @(negedge clk);
`ifdef BP_NBF_CMD_ISSUER_ERR_CNT_EN
        chk("err_cnt3", 128'(err_cnt), 128'(3));
`else
        chk("err_cnt0", 128'(err_cnt), 128'(0));
`endif
        chk("err_no_v", 128'(cmd_v), 128'(0));
        chk("err_ready", 128'(nbf_ready), 128'(1));

        // Finish with one outstanding, then DONE is sticky.
        w8(40'h300, 64'hFEED);
        ctl(8'hFF);
        chk("fin_done0", 128'(done), 128'(0));
        chk("fin_rdy0", 128'(nbf_ready), 128'(0));
        repeat (3) @(negedge clk);
        chk("fin_done1", 128'(done), 128'(0));
        resp_pulse();
        chk("fin_done", 128'(done), 128'(1));
        nbf   = {8'h03, 40'h400, 64'h99};
        nbf_v = 1'b1;
        repeat (5) @(negedge clk);
        chk("done_sticky", 128'(done), 128'(1));
        chk("done_rdy", 128'(nbf_ready), 128'(0));
        chk("done_v", 128'(cmd_v), 128'(0));
        chk("done_sb", 128'(sb.size()), 128'(0));
        nbf_v = 1'b0;

        // Asynchronous reset in the middle of ISSUE.
        do_reset();
        repeat (3) w8(40'h500, 64'h7);
        wait_sb_empty();
        yumi_en = 1'b0;
        w8(40'h600, 64'h8);
        chk("mid_v", 128'(cmd_v), 128'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("v_async_drop", 128'(cmd_v), 128'(0));
        chk("rdy_async", 128'(nbf_ready), 128'(1));
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) resp_pulse();
        yumi_en = 1'b1;
        base = yumi_cnt;
        for (int i = 0; i < 4; i++) begin
            w8(40'h700 + 40'(i * 8), 64'(i + 16));
        end
        wait_sb_empty();
        repeat (2) @(negedge clk);
        chk("post_rst_yumis", 128'(yumi_cnt - base), 128'(4));
        w8(40'h800, 64'h42);
        repeat (4) @(negedge clk);
        chk("post_rst_cap", 128'(cmd_v), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
